scr_stack_ctrl: RTL and testbench

- Sequencer between the register file / control unit and the scratch RAM.
- Turns one-shot memory ops (PUSH, POP, CALL, RET, ST, LD, WSP) into scratch-RAM address/data/write-enable traffic.
- Owns the stack pointer and stack depth, and returns read data (8-bit register value or 10-bit return address) with a done pulse.
- Sits directly upstream of the scratch RAM; the RAM has a synchronous write on CLK and an asynchronous read.

---
 rtl/scr_stack_ctrl_pkg.sv | 42 ++++
 rtl/scr_stack_ctrl_if.sv | 39 +++
 rtl/scr_stack_ctrl_sp_unit.sv | 65 ++++++
 rtl/scr_stack_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_scr_stack_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/scr_stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scr_stack_pkg
// Shared types and constants for the scratch-RAM stack sequencer:
//   op_t    - one-shot memory operation codes presented on OP
//   state_t - sequencer states (IDLE -> ACCESS -> FIN)
//   SCR_AW / SCR_DW / REG_W - scratch address, scratch data and register widths
// Helper functions classify the stack-growing and stack-shrinking operations.
// -----------------------------------------------------------------------------
package scr_stack_pkg;

    localparam int SCR_AW = 8;
    localparam int SCR_DW = 10;
    localparam int REG_W  = 8;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        ST   = 3'd5,
        LD   = 3'd6,
        WSP  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FIN    = 2'd2
    } state_t;

    // Operations that grow the stack (write at SP-1, SP decrements).
    function automatic logic is_push_op(input op_t op);
        return (op == PUSH) || (op == CALL);
    endfunction

    // Operations that shrink the stack (read at SP, SP increments).
    function automatic logic is_pop_op(input op_t op);
        return (op == POP) || (op == RET);
    endfunction

endpackage

// File: rtl/scr_stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// scr_stack_ctrl_if
// Bundles the request side (control unit / register file) and the scratch-RAM
// side of the stack sequencer.
//   slave  : the sequencer itself (takes requests and RAM read data, drives
//            RAM address/data/write-enable and the result/status signals)
//   master : the environment (control unit plus scratch RAM)
// -----------------------------------------------------------------------------
interface scr_stack_ctrl_if;

    scr_stack_pkg::op_t                        OP;
    logic                                      OP_VALID;
    logic [scr_stack_pkg::REG_W-1:0]           DX;
    logic [scr_stack_pkg::REG_W-1:0]           DY;
    logic [scr_stack_pkg::SCR_AW-1:0]          IMM_ADDR;
    logic                                      USE_IMM;
    logic [scr_stack_pkg::SCR_DW-1:0]          PC_NEXT;
    logic [scr_stack_pkg::SCR_DW-1:0]          SCR_DATA_OUT;
    logic [scr_stack_pkg::SCR_AW-1:0]          SCR_ADDR;
    logic [scr_stack_pkg::SCR_DW-1:0]          SCR_DATA_IN;
    logic                                      SCR_WE;
    logic [scr_stack_pkg::REG_W-1:0]           LD_DATA;
    logic [scr_stack_pkg::SCR_DW-1:0]          RET_ADDR;
    logic                                      DONE;
    logic                                      ERR;
    logic                                      BUSY;
    logic [scr_stack_pkg::REG_W-1:0]           SP;

    modport slave (
        input  OP, OP_VALID, DX, DY, IMM_ADDR, USE_IMM, PC_NEXT, SCR_DATA_OUT,
        output SCR_ADDR, SCR_DATA_IN, SCR_WE, LD_DATA, RET_ADDR, DONE, ERR, BUSY, SP
    );

    modport master (
        output OP, OP_VALID, DX, DY, IMM_ADDR, USE_IMM, PC_NEXT, SCR_DATA_OUT,
        input  SCR_ADDR, SCR_DATA_IN, SCR_WE, LD_DATA, RET_ADDR, DONE, ERR, BUSY, SP
    );

endinterface

// File: rtl/scr_stack_ctrl_sp_unit.sv
// -----------------------------------------------------------------------------
// sp_unit
// Stack pointer register plus occupancy (depth) counter.
//   clk, rst  : clock, synchronous active-high reset (SP <= SP_RESET, depth <= 0)
//   push      : SP <= SP-1, depth+1 (suppressed when full)
//   pop       : SP <= SP+1, depth-1 (suppressed when empty)
//   load      : SP <= load_val, depth <= 0 (highest priority after reset)
//   sp        : current stack pointer
//   full/empty: depth == STACK_DEPTH / depth == 0
// SP arithmetic wraps modulo 256.
// -----------------------------------------------------------------------------
module sp_unit
    import scr_stack_pkg::*;
#(
    parameter int               STACK_DEPTH = 32,
    parameter logic [REG_W-1:0] SP_RESET    = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [REG_W-1:0] load_val,
    output logic [REG_W-1:0] sp,
    output logic             full,
    output logic             empty
);

    localparam int                 DEPTH_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [REG_W-1:0]   sp_r;
    logic [DEPTH_W-1:0] depth_r;
    logic               full_s;
    logic               empty_s;

    assign full_s  = (depth_r >= DEPTH_FULL);
    assign empty_s = (depth_r == {DEPTH_W{1'b0}});

    // SP and depth update; overflow/underflow requests leave both untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r    <= SP_RESET;
            depth_r <= {DEPTH_W{1'b0}};
        end else if (load) begin
            sp_r    <= load_val;
            depth_r <= {DEPTH_W{1'b0}};
        end else if (push && !full_s) begin
            sp_r    <= sp_r - 8'd1;
            depth_r <= depth_r + DEPTH_ONE;
        end else if (pop && !empty_s) begin
            sp_r    <= sp_r + 8'd1;
            depth_r <= depth_r - DEPTH_ONE;
        end else begin
            sp_r    <= sp_r;
            depth_r <= depth_r;
        end
    end

    assign sp    = sp_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/scr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// scr_stack_ctrl
// Sequencer between the register file / control unit and the scratch RAM.
// Each accepted op runs IDLE -> ACCESS -> FIN: RAM address/data/write-enable
// are registered at the accept edge so they are stable for the whole ACCESS
// cycle; the RAM write and read-data capture happen at the end of ACCESS, and
// DONE/ERR are presented for one cycle in FIN.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - synchronous reset, active-high
//   bus  - scr_stack_ctrl_if.slave: request inputs (OP, OP_VALID, DX, DY,
//          IMM_ADDR, USE_IMM, PC_NEXT), RAM side (SCR_ADDR, SCR_DATA_IN,
//          SCR_WE, SCR_DATA_OUT), results (LD_DATA, RET_ADDR, DONE, ERR),
//          status (BUSY, SP)
// -----------------------------------------------------------------------------
module scr_stack_ctrl
    import scr_stack_pkg::*;
#(
    parameter int               STACK_DEPTH = 32,
    parameter logic [REG_W-1:0] SP_RESET    = 8'h00
) (
    input  logic             CLK,
    input  logic             RST,
    scr_stack_ctrl_if.slave  bus
);

    state_t              state_r;
    state_t              state_nxt_s;
    op_t                 op_r;
    logic [REG_W-1:0]    dx_r;

    logic [SCR_AW-1:0]   scr_addr_r;
    logic [SCR_DW-1:0]   scr_din_r;
    logic                scr_we_r;
    logic [REG_W-1:0]    ld_data_r;
    logic [SCR_DW-1:0]   ret_addr_r;
    logic                done_r;
    logic                err_r;

    logic                accept_s;
    logic [SCR_AW-1:0]   addr_sel_s;
    logic [SCR_AW-1:0]   scr_addr_nxt_s;
    logic [SCR_DW-1:0]   scr_din_nxt_s;
    logic                scr_we_nxt_s;
    logic                sp_push_s;
    logic                sp_pop_s;
    logic                sp_load_s;
    logic                cap_ld_s;
    logic                cap_ret_s;
    logic                err_nxt_s;
    logic                done_nxt_s;

    logic [REG_W-1:0]    sp_s;
    logic                full_s;
    logic                empty_s;

    assign accept_s   = bus.OP_VALID && (bus.OP != NOP);
    assign addr_sel_s = bus.USE_IMM ? bus.IMM_ADDR : bus.DY;

    sp_unit #(
        .STACK_DEPTH (STACK_DEPTH),
        .SP_RESET    (SP_RESET)
    ) u_sp_unit (
        .clk      (CLK),
        .rst      (RST),
        .push     (sp_push_s),
        .pop      (sp_pop_s),
        .load     (sp_load_s),
        .load_val (dx_r),
        .sp       (sp_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; requests outside IDLE are dropped, not queued.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = FIN;
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: RAM drive values for the coming ACCESS cycle, and
    // SP/capture/status strobes taking effect at the end of ACCESS.
    // SP and depth cannot change between accept and ACCESS, so the full/empty
    // decisions made here and in ACCESS agree.
    always_comb begin
        scr_addr_nxt_s = {SCR_AW{1'b0}};
        scr_din_nxt_s  = {SCR_DW{1'b0}};
        scr_we_nxt_s   = 1'b0;
        sp_push_s      = 1'b0;
        sp_pop_s       = 1'b0;
        sp_load_s      = 1'b0;
        cap_ld_s       = 1'b0;
        cap_ret_s      = 1'b0;
        err_nxt_s      = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (bus.OP)
                        PUSH: begin
                            scr_addr_nxt_s = sp_s - 8'd1;
                            scr_din_nxt_s  = {2'b00, bus.DX};
                            scr_we_nxt_s   = !full_s;
                        end
                        CALL: begin
                            scr_addr_nxt_s = sp_s - 8'd1;
                            scr_din_nxt_s  = bus.PC_NEXT;
                            scr_we_nxt_s   = !full_s;
                        end
                        POP, RET: begin
                            scr_addr_nxt_s = sp_s;
                        end
                        ST: begin
                            scr_addr_nxt_s = addr_sel_s;
                            scr_din_nxt_s  = {2'b00, bus.DX};
                            scr_we_nxt_s   = 1'b1;
                        end
                        LD: begin
                            scr_addr_nxt_s = addr_sel_s;
                        end
                        default: begin
                            scr_addr_nxt_s = {SCR_AW{1'b0}};
                        end
                    endcase
                end else begin
                    scr_we_nxt_s = 1'b0;
                end
            end
            ACCESS: begin
                done_nxt_s = 1'b1;
                if (is_push_op(op_r)) begin
                    sp_push_s = !full_s;
                    err_nxt_s = full_s;
                end else if (is_pop_op(op_r)) begin
                    sp_pop_s  = !empty_s;
                    cap_ld_s  = (op_r == POP) && !empty_s;
                    cap_ret_s = (op_r == RET) && !empty_s;
                    err_nxt_s = empty_s;
                end else begin
                    cap_ld_s  = (op_r == LD);
                    sp_load_s = (op_r == WSP);
                end
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Request latch, registered RAM drive, and result/status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r       <= NOP;
            dx_r       <= {REG_W{1'b0}};
            scr_addr_r <= {SCR_AW{1'b0}};
            scr_din_r  <= {SCR_DW{1'b0}};
            scr_we_r   <= 1'b0;
            ld_data_r  <= {REG_W{1'b0}};
            ret_addr_r <= {SCR_DW{1'b0}};
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if ((state_r == IDLE) && accept_s) begin
                op_r <= bus.OP;
                dx_r <= bus.DX;
            end
            scr_addr_r <= scr_addr_nxt_s;
            scr_din_r  <= scr_din_nxt_s;
            scr_we_r   <= scr_we_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            if (cap_ld_s) begin
                ld_data_r <= bus.SCR_DATA_OUT[REG_W-1:0];
            end
            if (cap_ret_s) begin
                ret_addr_r <= bus.SCR_DATA_OUT;
            end
        end
    end

    // Write enable is gated by reset so an op interrupted in ACCESS never writes.
    assign bus.SCR_WE      = scr_we_r & ~RST;
    assign bus.SCR_ADDR    = scr_addr_r;
    assign bus.SCR_DATA_IN = scr_din_r;
    assign bus.LD_DATA     = ld_data_r;
    assign bus.RET_ADDR    = ret_addr_r;
    assign bus.DONE        = done_r;
    assign bus.ERR         = err_r;
    assign bus.BUSY        = (state_r != IDLE);
    assign bus.SP          = sp_s;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
module tb_scr_stack_ctrl;
    import scr_stack_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    scr_stack_ctrl_if bus();

    scr_stack_ctrl #(
        .STACK_DEPTH (32),
        .SP_RESET    (8'h00)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Scratch RAM: synchronous write, asynchronous read.
    logic [9:0] ram [256];
    always @(posedge CLK) begin
        if (bus.SCR_WE) ram[bus.SCR_ADDR] <= bus.SCR_DATA_IN;
    end
    assign bus.SCR_DATA_OUT = ram[bus.SCR_ADDR];

    int done_cnt = 0;
    always @(posedge CLK) begin
        if (bus.DONE) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        op_t        op;
        logic [7:0] dx;
        logic [7:0] dy;
        logic [7:0] imm;
        logic       use_imm;
        logic [9:0] pc;
        logic       poke;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [9:0] exp_din;
        logic       exp_err;
        logic [7:0] exp_ld;
        logic [9:0] exp_ret;
        logic [7:0] exp_sp;
    } vec_t;

    vec_t tbl [12];
    vec_t exp_q [$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(op_t op, logic [7:0] dx, logic [7:0] dy, logic [7:0] imm,
                                logic use_imm, logic [9:0] pc, logic poke, logic we,
                                logic [7:0] a, logic [9:0] d, logic err, logic [7:0] ld,
                                logic [9:0] ret, logic [7:0] sp);
        vec_t v;
        v.op = op; v.dx = dx; v.dy = dy; v.imm = imm; v.use_imm = use_imm; v.pc = pc;
        v.poke = poke; v.exp_we = we; v.exp_addr = a; v.exp_din = d; v.exp_err = err;
        v.exp_ld = ld; v.exp_ret = ret; v.exp_sp = sp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic check_reset_state();
        check("rst_sp",       32'(bus.SP),       32'h00);
        check("rst_busy",     32'(bus.BUSY),     32'h0);
        check("rst_done",     32'(bus.DONE),     32'h0);
        check("rst_err",      32'(bus.ERR),      32'h0);
        check("rst_we",       32'(bus.SCR_WE),   32'h0);
        check("rst_addr",     32'(bus.SCR_ADDR), 32'h00);
        check("rst_ld_data",  32'(bus.LD_DATA),  32'h00);
        check("rst_ret_addr", 32'(bus.RET_ADDR), 32'h000);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_reset_state();
    endtask

    // Drive one op, check ACCESS-cycle RAM traffic, then the DONE-cycle results.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   wait_n;
        int   d0;
        @(negedge CLK);
        check("idle_before", 32'(bus.BUSY), 32'h0);
        bus.OP = v.op; bus.DX = v.dx; bus.DY = v.dy; bus.IMM_ADDR = v.imm;
        bus.USE_IMM = v.use_imm; bus.PC_NEXT = v.pc; bus.OP_VALID = 1'b1;
        exp_q.push_back(v);
        n_vec++;
        d0 = done_cnt;
        @(negedge CLK);
        if (v.poke) begin
            // Request held and altered while busy: must be ignored.
            bus.OP = PUSH; bus.DX = 8'hEE; bus.DY = 8'h00; bus.USE_IMM = 1'b0;
            bus.PC_NEXT = 10'h3EE;
        end else begin
            bus.OP_VALID = 1'b0;
        end
        #1;
        check("access_busy", 32'(bus.BUSY), 32'h1);
        check("access_we", 32'(bus.SCR_WE), 32'(v.exp_we));
        if (v.exp_we) begin
            check("access_addr", 32'(bus.SCR_ADDR), 32'(v.exp_addr));
            check("access_din",  32'(bus.SCR_DATA_IN), 32'(v.exp_din));
        end
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        wait_n = 0;
        while (!bus.DONE && wait_n < 6) begin
            @(negedge CLK);
            wait_n++;
        end
        check("done_latency", 32'(wait_n), 32'h0);
        e = exp_q.pop_front();
        check("err",      32'(bus.ERR),      32'(e.exp_err));
        check("ld_data",  32'(bus.LD_DATA),  32'(e.exp_ld));
        check("ret_addr", 32'(bus.RET_ADDR), 32'(e.exp_ret));
        check("sp",       32'(bus.SP),       32'(e.exp_sp));
        @(negedge CLK);
        check("done_pulse", 32'(bus.DONE), 32'h0);
        check("idle_after", 32'(bus.BUSY), 32'h0);
        check("done_count", 32'(done_cnt - d0), 32'h1);
    endtask

    initial begin
        int d0;
        vec_t v;

        //            op    dx     dy     imm    ui    pc      pk    we    addr   din     err   ld     ret     sp
        tbl[0]  = mk(PUSH, 8'h0A, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1, 8'hFF, 10'h00A, 1'b0, 8'h00, 10'h000, 8'hFF);
        tbl[1]  = mk(POP,  8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h0A, 10'h000, 8'h00);
        tbl[2]  = mk(CALL, 8'h33, 8'h00, 8'h00, 1'b0, 10'h214, 1'b0, 1'b1, 8'hFF, 10'h214, 1'b0, 8'h0A, 10'h000, 8'hFF);
        tbl[3]  = mk(RET,  8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h0A, 10'h214, 8'h00);
        tbl[4]  = mk(ST,   8'h07, 8'h99, 8'h44, 1'b1, 10'h000, 1'b1, 1'b1, 8'h44, 10'h007, 1'b0, 8'h0A, 10'h214, 8'h00);
        tbl[5]  = mk(LD,   8'h00, 8'h44, 8'h12, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h07, 10'h214, 8'h00);
        tbl[6]  = mk(POP,  8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 8'h07, 10'h214, 8'h00);
        tbl[7]  = mk(RET,  8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 8'h07, 10'h214, 8'h00);
        tbl[8]  = mk(WSP,  8'h10, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h07, 10'h214, 8'h10);
        tbl[9]  = mk(PUSH, 8'h5C, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1, 8'h0F, 10'h05C, 1'b0, 8'h07, 10'h214, 8'h0F);
        tbl[10] = mk(LD,   8'h00, 8'h00, 8'h0F, 1'b1, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h5C, 10'h214, 8'h0F);
        tbl[11] = mk(WSP,  8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h5C, 10'h214, 8'h00);

        RST = 1'b1;
        bus.OP = NOP; bus.OP_VALID = 1'b0; bus.DX = 8'h00; bus.DY = 8'h00;
        bus.IMM_ADDR = 8'h00; bus.USE_IMM = 1'b0; bus.PC_NEXT = 10'h000;

        do_reset();

        // NOP with OP_VALID is never accepted.
        @(negedge CLK);
        bus.OP = NOP; bus.OP_VALID = 1'b1;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        check("nop_not_accepted", 32'(bus.BUSY), 32'h0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Fill the stack (32 entries), then one overflowing PUSH.
        for (int i = 0; i < 32; i++) begin
            v = mk(PUSH, 8'(8'h80 + i), 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1,
                   8'(8'hFF - i), 10'(10'h080 + i), 1'b0, 8'h5C, 10'h214, 8'(8'hFF - i));
            run_vec(v);
        end
        run_vec(mk(PUSH, 8'h33, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 8'h5C, 10'h214, 8'hE0));
        run_vec(mk(CALL, 8'h00, 8'h00, 8'h00, 1'b0, 10'h1AB, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 8'h5C, 10'h214, 8'hE0));

        // Underflow straight after reset.
        do_reset();
        run_vec(mk(POP, 8'h00, 8'h00, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 8'h00, 10'h000, 8'h00));

        // Reset during ACCESS of a PUSH: no write, no DONE.
        @(negedge CLK);
        bus.OP = PUSH; bus.DX = 8'hAA; bus.OP_VALID = 1'b1;
        n_vec++;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        #1;
        check("midrst_we_before", 32'(bus.SCR_WE), 32'h1);
        RST = 1'b1;
        #1;
        check("midrst_we_gated", 32'(bus.SCR_WE), 32'h0);
        d0 = done_cnt;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_sp",   32'(bus.SP),   32'h00);
        check("midrst_busy", 32'(bus.BUSY), 32'h0);
        check("midrst_done", 32'(bus.DONE), 32'h0);
        repeat (3) @(negedge CLK);
        check("midrst_no_done", 32'(done_cnt - d0), 32'h0);
        run_vec(mk(LD, 8'h00, 8'h00, 8'hFF, 1'b1, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 8'h80, 10'h000, 8'h00));

        // One DONE per accepted op; the aborted one and ignored pokes add none.
        check("done_total", 32'(done_cnt), 32'(n_vec - 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
